// File: rtl/uart_byte_tx_module.sv
// UART byte transmitter.
// Takes one byte per valid/ready handshake and sends it on tx_pin, LSB first.
// Frame layout: start bit, 8 data bits, optional parity bit, then 1 or 2 stop bits.
// tx_ack pulses for one clock when the last stop bit completes.
// tx_frame_ack pulses once the line has then stayed idle for IDLE_CYCLE bit periods.
module uart_byte_tx_module #(
  parameter int CLK_FRE    = 50,      // clock frequency in MHz
  parameter int BAUD_RATE  = 115200,  // serial baud rate
  parameter int PARITY     = 0,       // 0 none, 1 odd, 2 even
  parameter int STOP_BITS  = 1,       // 1 or 2
  parameter int IDLE_CYCLE = 2        // idle bit periods before tx_frame_ack
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_data_ready,
  output logic       tx_ack,
  output logic       tx_frame_ack,
  output logic       tx_busy,
  output logic       tx_pin
);

  localparam int unsigned CYCLE      = CLK_FRE * 1000000 / BAUD_RATE;
  localparam logic [15:0] CYC_LAST   = 16'(CYCLE - 1);
  localparam int unsigned IDLE_TIME  = CYCLE * IDLE_CYCLE;
  localparam logic [31:0] IDLE_MAX   = 32'(IDLE_TIME);
  localparam logic [2:0]  STOP_LAST  = 3'(STOP_BITS - 1);
  localparam bit          HAS_PARITY = (PARITY != 0);
  localparam bit          ODD_PARITY = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND_BYTE,
    S_PARITY,
    S_STOP
  } state_t;

  state_t      state;
  logic [15:0] cycle_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_shift;
  logic        parity_bit;
  logic [31:0] idle_cnt;
  logic        bit_done;

  assign bit_done = (cycle_cnt == CYC_LAST);

  // Frame sequencer: registered line level, handshake flags and idle-time tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cycle_cnt     <= '0;
      bit_cnt       <= '0;
      tx_shift      <= '0;
      parity_bit    <= 1'b0;
      idle_cnt      <= IDLE_MAX;
      tx_pin        <= 1'b1;
      tx_data_ready <= 1'b1;
      tx_busy       <= 1'b0;
      tx_ack        <= 1'b0;
      tx_frame_ack  <= 1'b0;
    end else begin
      tx_ack       <= 1'b0;
      tx_frame_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          cycle_cnt <= '0;
          bit_cnt   <= '0;
          if (tx_data_valid) begin
            tx_shift      <= tx_data;
            parity_bit    <= ODD_PARITY ? ~(^tx_data) : ^tx_data;
            tx_pin        <= 1'b0;
            tx_data_ready <= 1'b0;
            tx_busy       <= 1'b1;
            state         <= S_START;
          end else begin
            tx_pin <= 1'b1;
            // The idle counter saturates, so tx_frame_ack fires once per quiet period.
            if (idle_cnt < IDLE_MAX) begin
              idle_cnt <= idle_cnt + 32'd1;
              if (idle_cnt == IDLE_MAX - 32'd1) begin
                tx_frame_ack <= 1'b1;
              end
            end
          end
        end

        S_START: begin
          if (bit_done) begin
            cycle_cnt <= '0;
            tx_pin    <= tx_shift[0];
            state     <= S_SEND_BYTE;
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end

        S_SEND_BYTE: begin
          if (bit_done) begin
            cycle_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              if (HAS_PARITY) begin
                tx_pin <= parity_bit;
                state  <= S_PARITY;
              end else begin
                tx_pin <= 1'b1;
                state  <= S_STOP;
              end
            end else begin
              // The next data bit is always at index 1 because the register shifts right as bits go out.
              bit_cnt  <= bit_cnt + 3'd1;
              tx_pin   <= tx_shift[1];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end

        S_PARITY: begin
          if (bit_done) begin
            cycle_cnt <= '0;
            bit_cnt   <= '0;
            tx_pin    <= 1'b1;
            state     <= S_STOP;
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end

        S_STOP: begin
          if (bit_done) begin
            cycle_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt       <= '0;
              state         <= S_IDLE;
              tx_ack        <= 1'b1;
              tx_data_ready <= 1'b1;
              tx_busy       <= 1'b0;
              idle_cnt      <= '0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end

        default: begin
          state         <= S_IDLE;
          cycle_cnt     <= '0;
          bit_cnt       <= '0;
          tx_pin        <= 1'b1;
          tx_data_ready <= 1'b1;
          tx_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_tx_module.sv
// Self-checking bench for uart_byte_tx_module.
// Three instances (no parity / 1 stop, even / 2 stop, odd / 2 stop) at CYCLE=10.
// A timing-based reference model tracks the expected outputs of every instance on every clock.
module tb_uart_byte_tx_module;

  localparam int unsigned CYC    = 10;
  localparam int unsigned IDLE_T = 20;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data       [3];
  logic       tx_data_valid [3];
  logic       tx_data_ready [3];
  logic       tx_ack        [3];
  logic       tx_frame_ack  [3];
  logic       tx_busy       [3];
  logic       tx_pin        [3];

  int n_cmp;
  int n_err;
  bit chk_en;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_byte_tx_module #(
      .CLK_FRE   (1),
      .BAUD_RATE (100000),
      .PARITY    (g == 0 ? 0 : (g == 1 ? 2 : 1)),
      .STOP_BITS (g == 0 ? 1 : 2),
      .IDLE_CYCLE(2)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tx_data      (tx_data[g]),
      .tx_data_valid(tx_data_valid[g]),
      .tx_data_ready(tx_data_ready[g]),
      .tx_ack       (tx_ack[g]),
      .tx_frame_ack (tx_frame_ack[g]),
      .tx_busy      (tx_busy[g]),
      .tx_pin       (tx_pin[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int unsigned par_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 1);
  endfunction

  function automatic int unsigned stop_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int unsigned nbits(input int k);
    return 9 + ((par_of(k) != 0) ? 1 : 0) + stop_of(k);
  endfunction

  // Line bits in transmit order; bit i is the level during bit period i.
  function automatic logic [11:0] mk_frame(input int k, input logic [7:0] d);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (par_of(k) == 2) f[9] = ^d;
    if (par_of(k) == 1) f[9] = ~(^d);
    return f;
  endfunction

  typedef struct {
    bit          busy;
    int unsigned t;      // clocks since the handshake edge
    logic [11:0] frame;
    int unsigned idle;   // clocks of idle since last frame end
    bit          ack;
    bit          fack;
  } mstate_t;

  mstate_t m [3];

  function automatic mstate_t m_reset();
    mstate_t s;
    s.busy = 0; s.t = 0; s.frame = '1; s.idle = IDLE_T; s.ack = 0; s.fack = 0;
    return s;
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic v, input logic [7:0] d, input int k);
    mstate_t n;
    n = s;
    n.ack = 0;
    n.fack = 0;
    if (s.busy) begin
      n.t = s.t + 1;
      if (n.t == nbits(k) * CYC) begin
        n.busy = 0;
        n.ack  = 1;
        n.idle = 0;
      end
    end else if (v) begin
      n.busy  = 1;
      n.t     = 0;
      n.frame = mk_frame(k, d);
    end else if (s.idle < IDLE_T) begin
      n.idle = s.idle + 1;
      n.fack = (n.idle == IDLE_T);
    end
    return n;
  endfunction

  // {pin, ready, busy, ack, frame_ack}
  function automatic logic [4:0] exp_out(input mstate_t s);
    logic p;
    p = s.busy ? s.frame[s.t / CYC] : 1'b1;
    return {p, ~s.busy, s.busy, s.ack, s.fack};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) m[k] <= m_reset();
    end else begin
      for (int k = 0; k < 3; k++) m[k] <= step(m[k], tx_data_valid[k], tx_data[k], k);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] dut_out(input int k);
    return {tx_pin[k], tx_data_ready[k], tx_busy[k], tx_ack[k], tx_frame_ack[k]};
  endfunction

  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 3; k++)
        chk($sformatf("scoreboard_dut%0d", k), 32'(dut_out(k)), 32'(exp_out(m[k])));
    end
  endtask

  // One frame from the table: mid-bit line levels, tx_ack timing and tx_frame_ack timing.
  task automatic send_table(input int k, input logic [7:0] d, input logic [11:0] bits, input int n);
    tx_data[k]       = d;
    tx_data_valid[k] = 1'b1;
    tick();
    tx_data_valid[k] = 1'b0;
    chk("hs_busy", 32'(tx_busy[k]), 32'd1);
    chk("hs_ready", 32'(tx_data_ready[k]), 32'd0);
    for (int c = 0; c < n * 10 + 20; c++) begin
      if (c == 25) tx_data[k] = ~d;
      if ((c % 10) == 5 && c < n * 10)
        chk($sformatf("tbl_dut%0d_bit%0d", k, c / 10), 32'(tx_pin[k]), 32'(bits[c / 10]));
      if (c == n * 10 - 1) chk("tbl_ack_early", 32'(tx_ack[k]), 32'd0);
      if (c == n * 10) begin
        chk("tbl_ack", 32'(tx_ack[k]), 32'd1);
        chk("tbl_ready_end", 32'(tx_data_ready[k]), 32'd1);
      end
      if (c == n * 10 + 19) chk("tbl_fack_early", 32'(tx_frame_ack[k]), 32'd0);
      tick();
    end
    chk("tbl_frame_ack", 32'(tx_frame_ack[k]), 32'd1);
  endtask

  typedef struct {
    int          k;
    logic [7:0]  d;
    logic [11:0] bits;
    int          n;
  } vec_t;

  vec_t tbl [4];
  int   cnt;
  int   lowcnt;
  int unsigned gap [3];

  initial begin
    tbl[0] = '{0, 8'h81, 12'hF02, 10};
    tbl[1] = '{0, 8'h55, 12'hEAA, 10};
    tbl[2] = '{1, 8'h03, 12'hC06, 12};
    tbl[3] = '{2, 8'h03, 12'hE06, 12};

    n_cmp  = 0;
    n_err  = 0;
    chk_en = 0;
    for (int k = 0; k < 3; k++) begin
      tx_data[k]       = 8'h00;
      tx_data_valid[k] = 1'b0;
      gap[k]           = 0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk("reset_outputs", 32'(dut_out(k)), 32'h18);
    repeat (3) tick();
    rst_n  = 1'b1;
    chk_en = 1;

    // Quiet line after reset: no frame_ack without a frame.
    cnt = 0;
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < 3; k++) if (tx_frame_ack[k]) cnt++;
      tick();
    end
    chk("idle_no_frame_ack", 32'(cnt), 32'd0);

    // Reset during data bit 3 of 0xF0.
    tx_data[0]       = 8'hF0;
    tx_data_valid[0] = 1'b1;
    tick();
    tx_data_valid[0] = 1'b0;
    repeat (45) tick();
    chk("rst_pre_pin", 32'(tx_pin[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_pin", 32'(tx_pin[0]), 32'd1);
    chk("rst_async_busy", 32'(tx_busy[0]), 32'd0);
    chk("rst_async_ready", 32'(tx_data_ready[0]), 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 150; c++) begin
      if (tx_ack[0]) cnt++;
      tick();
    end
    chk("rst_no_ack", 32'(cnt), 32'd0);

    // Table-driven frames.
    for (int i = 0; i < 4; i++) send_table(tbl[i].k, tbl[i].d, tbl[i].bits, tbl[i].n);

    // Back-to-back 0xA5 then 0x5A with valid held.
    tx_data[0]       = 8'hA5;
    tx_data_valid[0] = 1'b1;
    tick();
    tx_data[0] = 8'h5A;
    lowcnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (!tx_data_ready[0]) lowcnt++;
      tick();
    end
    chk("b2b_ready_low_1", 32'(lowcnt), 32'd100);
    chk("b2b_gap_ready", 32'(tx_data_ready[0]), 32'd1);
    chk("b2b_gap_pin", 32'(tx_pin[0]), 32'd1);
    tick();
    tx_data_valid[0] = 1'b0;
    chk("b2b_start2_pin", 32'(tx_pin[0]), 32'd0);
    chk("b2b_start2_busy", 32'(tx_busy[0]), 32'd1);
    lowcnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (!tx_data_ready[0]) lowcnt++;
      tick();
    end
    chk("b2b_ready_low_2", 32'(lowcnt), 32'd100);
    chk("b2b_ack_2", 32'(tx_ack[0]), 32'd1);
    repeat (30) tick();

    // Valid pulsed while busy is ignored.
    tx_data[0]       = 8'h12;
    tx_data_valid[0] = 1'b1;
    tick();
    tx_data_valid[0] = 1'b0;
    cnt = 0;
    for (int c = 0; c < 140; c++) begin
      if (c == 30) begin tx_data_valid[0] = 1'b1; tx_data[0] = 8'h77; end
      if (c == 31) tx_data_valid[0] = 1'b0;
      if (tx_ack[0]) cnt++;
      tick();
    end
    chk("busy_pulse_ack_count", 32'(cnt), 32'd1);
    chk("busy_pulse_idle", 32'(tx_busy[0]), 32'd0);

    // Randomized traffic with noise on valid/data while busy.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        if (tx_data_ready[k]) begin
          if (gap[k] > 0) begin
            gap[k]--;
            tx_data_valid[k] = 1'b0;
          end else begin
            tx_data_valid[k] = 1'b1;
            tx_data[k]       = 8'($urandom);
            gap[k]           = $urandom_range(0, 30);
          end
        end else begin
          tx_data_valid[k] = 1'($urandom_range(0, 1));
          tx_data[k]       = 8'($urandom);
        end
      end
      tick();
    end
    for (int k = 0; k < 3; k++) tx_data_valid[k] = 1'b0;
    repeat (200) tick();
    for (int k = 0; k < 3; k++) chk("drain_idle", 32'(tx_busy[k]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_byte_tx_module.md
# uart_byte_tx_module

UART byte transmitter: accepts one byte per valid/ready handshake and serialises it on `tx_pin` as start bit, 8 data bits LSB first, optional parity and 1 or 2 stop bits. It is the transmit-side counterpart of the team's UART byte receiver and uses the same baud derivation and the same frame-idle pulse semantics. Typical placement is between a byte source (FIFO or command engine) and the board TX pin.

## Interface
- `CLK_FRE`, 50, clock frequency in MHz.
- `BAUD_RATE`, 115200, serial baud rate.
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1, stop bits per frame; legal values 1 or 2.
- `IDLE_CYCLE`, 2, bit periods of idle line after the last frame before `tx_frame_ack` fires.
- `clk  in  1  clock`
- `rst_n  in  1  reset, asynchronous, active-low`
- `tx_data  in  8  byte to send; sampled only on handshake`
- `tx_data_valid  in  1  source has a byte`
- `tx_data_ready  out  1  block can accept a byte (high only in S_IDLE)`
- `tx_ack  out  1  one-clock pulse: frame (last stop bit) completed`
- `tx_frame_ack  out  1  one-clock pulse: line idle IDLE_TIME after last frame`
- `tx_busy  out  1  frame in progress (state != S_IDLE)`
- `tx_pin  out  1  serial line, idle high`

## Operation
- CYCLE = CLK_FRE*1000000/BAUD_RATE clocks per bit, integer division. Constraint: 2 <= CYCLE <= 65535; `cycle_cnt` is 16 bits.
- P = 1 if PARITY != 0, else 0. N = 1 + 8 + P + STOP_BITS bits per frame.
- IDLE_TIME = CYCLE*IDLE_CYCLE clocks.
- States:
  - S_IDLE: `tx_pin`=1, `tx_data_ready`=1. On `tx_data_valid`, latch `tx_data` into the shift register, compute parity, go to S_START.
  - S_START: `tx_pin`=0 for CYCLE clocks, then go to S_SEND_BYTE.
  - S_SEND_BYTE: each data bit is held for CYCLE clocks, LSB first, with `bit_cnt` running 0..7. After bit 7, go to S_PARITY if P=1, otherwise S_STOP.
  - S_PARITY: hold one bit period. Even mode sends XOR of the data bits; odd mode sends its inverse. Then go to S_STOP.
  - S_STOP: `tx_pin`=1 for STOP_BITS*CYCLE clocks, then go to S_IDLE.
- `cycle_cnt` clears on every state change and at each bit boundary.
- `tx_pin` is a register. It never glitches and holds its level for whole bit periods.
- Changes on `tx_data` or `tx_data_valid` outside the handshake cycle have no effect.
- Idle counter: clears to 0 on `tx_ack`, increments while below IDLE_TIME and state is S_IDLE, and saturates at IDLE_TIME. `tx_frame_ack` pulses on the clock the counter reaches IDLE_TIME. A new handshake before that point restarts the wait from the next `tx_ack`.
- Reset value of the idle counter is IDLE_TIME (saturated). No `tx_frame_ack` is issued after reset until at least one frame has been sent.

## Timing
- Reset values: `tx_pin`=1, `tx_data_ready`=1, `tx_busy`=0, `tx_ack`=0, `tx_frame_ack`=0, state S_IDLE, all counters 0 except the idle counter.
- Handshake on edge E0 (`tx_data_valid` & `tx_data_ready`). On E0, `tx_pin` goes to 0 and `tx_busy` goes to 1. `tx_data_ready` is 0 from E0 until the frame ends.
- Data bit n starts at E0+(1+n)*CYCLE. Parity starts at E0+9*CYCLE. Stop starts at E0+(9+P)*CYCLE.
- Frame end at edge E0+N*CYCLE: state goes to S_IDLE, `tx_ack`=1 for exactly one clock, `tx_data_ready`=1, `tx_busy`=0.
- Back-to-back: with `tx_data_valid` held, the next handshake is at E0+N*CYCLE+1. The inter-frame gap is exactly 1 extra clock of high line.
- `tx_frame_ack` occurs IDLE_TIME clocks after `tx_ack`, provided there is no intervening handshake.
- `rst_n` asserted mid-frame: all outputs take reset values asynchronously, with `tx_pin`=1 immediately. The partial frame is abandoned and no `tx_ack` is issued.

## Test plan
Bench setting: CLK_FRE=1, BAUD_RATE=100000, giving CYCLE=10.
- PARITY=0, STOP_BITS=1, send 0x55: `tx_pin` sequence 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), 10 clocks each. `tx_ack` pulses at E0+100.
- PARITY=2, STOP_BITS=2, send 0x03: parity bit 0, stop high for 20 clocks, `tx_ack` at E0+120. Repeat with PARITY=1: parity bit 1.
- Back-to-back 0xA5 then 0x5A with valid held: the second start bit falls at E0+101. Changing `tx_data` mid-frame does not alter the bits on the line. `tx_data_ready` stays low for exactly 100 clocks per frame.
- IDLE_CYCLE=2, single byte: `tx_frame_ack` pulses once, 20 clocks after `tx_ack`. A run of 500 clocks with no traffic after reset produces no `tx_frame_ack`.
- Reset asserted during data bit 3 of 0xF0: `tx_pin`=1 at once and no `tx_ack`. After release, 0x81 is sent correctly: 0,1,0,0,0,0,0,0,1,1.
- `tx_data_valid` pulsed for 1 clock while busy: ignored, no second frame, `tx_ack` count is 1.
